// File: rtl/fib_seq_engine.sv
// ---------------------------------------------------------------------------
// fib_seq_engine
// Fibonacci sequence generator with a Wishbone slave register file. The
// generator runs from a single clock and is paced by a programmable
// clock-enable prescaler. It offers programmable seeds, single-step, a
// wrap/saturate overflow policy, an advance counter and a level interrupt.
//
// Ports:
//   wb_clk_i   system clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   wbs_*      Wishbone slave (stb/cyc/we/sel/dat_i/adr in, ack/dat_o out)
//   value      current term A
//   running    high while the sequencer is in RUN
//   irq        level interrupt, OVF & IRQ_EN
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 CTRL      bit0 EN, bit1 STEP (pulse), bit2 SAT, bit3 CLR (pulse), bit4 IRQ_EN
//   0x04 PRESCALE  reload value of the clock-enable prescaler
//   0x08 SEED0     reload value for A
//   0x0C SEED1     reload value for B
//   0x10 VALUE     A (read only)
//   0x14 NEXT      B (read only)
//   0x18 STATUS    bit0 OVF (write 1 to clear), bit1 running, bit2 halted
//   0x1C COUNT     number of advances since the last reload (read only)
// ---------------------------------------------------------------------------
module fib_seq_engine #(
  parameter int          WIDTH      = 30,
  parameter int          PRESCALE_W = 24,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [WIDTH-1:0] value,
  output logic             running,
  output logic             irq
);

  localparam logic [7:0] L_OFF_CTRL     = 8'h00;
  localparam logic [7:0] L_OFF_PRESCALE = 8'h04;
  localparam logic [7:0] L_OFF_SEED0    = 8'h08;
  localparam logic [7:0] L_OFF_SEED1    = 8'h0C;
  localparam logic [7:0] L_OFF_VALUE    = 8'h10;
  localparam logic [7:0] L_OFF_NEXT     = 8'h14;
  localparam logic [7:0] L_OFF_STATUS   = 8'h18;
  localparam logic [7:0] L_OFF_COUNT    = 8'h1C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic                  r_ack;
  logic [31:0]           r_datO;

  logic                  r_en;
  logic                  r_sat;
  logic                  r_irqEn;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [WIDTH-1:0]      r_seed0;
  logic [WIDTH-1:0]      r_seed1;

  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [31:0]           r_count;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_ovf;
  logic                  r_stepPend;

  logic                  w_req;
  logic                  w_hit;
  logic [7:0]            w_off;
  logic                  w_wr;
  logic                  w_wrCtrl;
  logic                  w_wrPre;
  logic                  w_wrSeed0;
  logic                  w_wrSeed1;
  logic                  w_wrStatus;
  logic                  w_clr;
  logic                  w_tick;
  logic                  w_advance;
  logic [WIDTH:0]        w_sum;
  logic                  w_ovfEvt;
  logic                  w_satHalt;
  logic [31:0]           w_rdData;
  logic                  w_unused;

  // Bus decode. A request is only accepted while ack is low, which is what
  // spaces back-to-back requests one idle cycle apart.
  assign w_req      = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_off      = wbs_adr_i[7:0];
  assign w_wr       = w_req & wbs_we_i & (wbs_sel_i == 4'hF) & w_hit;
  assign w_wrCtrl   = w_wr & (w_off == L_OFF_CTRL);
  assign w_wrPre    = w_wr & (w_off == L_OFF_PRESCALE);
  assign w_wrSeed0  = w_wr & (w_off == L_OFF_SEED0);
  assign w_wrSeed1  = w_wr & (w_off == L_OFF_SEED1);
  assign w_wrStatus = w_wr & (w_off == L_OFF_STATUS);
  assign w_clr      = w_wrCtrl & wbs_dat_i[3];

  // Advance sources: a prescaler tick in RUN or a pending single step in
  // IDLE. A prescaler rewrite restarts the spacing, so it cancels a tick on
  // the same edge. CLR outranks every advance.
  assign w_tick    = (r_state == S_RUN) & r_en & (r_cnt == r_prescale) & ~w_wrPre;
  assign w_advance = (w_tick | ((r_state == S_IDLE) & r_stepPend)) & ~w_clr;
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovfEvt  = w_advance & w_sum[WIDTH];
  assign w_satHalt = w_ovfEvt & r_sat;

  assign w_unused  = ^wbs_dat_i;

  // Read multiplexer; anything unmapped or outside the base window reads 0.
  always_comb begin
    w_rdData = '0;
    if (w_hit) begin
      case (w_off)
        L_OFF_CTRL:     w_rdData[4:0] = {r_irqEn, 1'b0, r_sat, 1'b0, r_en};
        L_OFF_PRESCALE: w_rdData[PRESCALE_W-1:0] = r_prescale;
        L_OFF_SEED0:    w_rdData[WIDTH-1:0] = r_seed0;
        L_OFF_SEED1:    w_rdData[WIDTH-1:0] = r_seed1;
        L_OFF_VALUE:    w_rdData[WIDTH-1:0] = r_a;
        L_OFF_NEXT:     w_rdData[WIDTH-1:0] = r_b;
        L_OFF_STATUS:   w_rdData[2:0] = {(r_state == S_HALT), (r_state == S_RUN), r_ovf};
        L_OFF_COUNT:    w_rdData = r_count;
        default:        w_rdData = '0;
      endcase
    end
  end

  // Acknowledge one cycle after an accepted request; read data is only
  // driven alongside ack and is held at zero otherwise.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ack  <= 1'b0;
      r_datO <= '0;
    end else if (w_req) begin
      r_ack  <= 1'b1;
      r_datO <= wbs_we_i ? 32'd0 : w_rdData;
    end else begin
      r_ack  <= 1'b0;
      r_datO <= '0;
    end
  end

  // Configuration registers. Saturation clears EN on the overflow edge; in
  // HALT an EN write only sticks when it comes with CLR, so CLR|EN resumes.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_sat      <= 1'b0;
      r_irqEn    <= 1'b0;
      r_prescale <= '0;
      r_seed0    <= '0;
      r_seed1    <= WIDTH'(1);
      r_stepPend <= 1'b0;
    end else begin
      if (w_wrCtrl) begin
        r_sat   <= wbs_dat_i[2];
        r_irqEn <= wbs_dat_i[4];
      end
      if (w_satHalt) begin
        r_en <= 1'b0;
      end else if (w_wrCtrl && ((r_state != S_HALT) || w_clr)) begin
        r_en <= wbs_dat_i[0];
      end
      if (w_wrPre) begin
        r_prescale <= wbs_dat_i[PRESCALE_W-1:0];
      end
      if (w_wrSeed0) begin
        r_seed0 <= wbs_dat_i[WIDTH-1:0];
      end
      if (w_wrSeed1) begin
        r_seed1 <= wbs_dat_i[WIDTH-1:0];
      end
      r_stepPend <= w_wrCtrl & wbs_dat_i[1] & (r_state == S_IDLE);
    end
  end

  // Sequence datapath: CLR reload, then overflow policy, then a plain advance.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= WIDTH'(1);
      r_count <= '0;
    end else if (w_clr) begin
      r_a     <= r_seed0;
      r_b     <= r_seed1;
      r_count <= '0;
    end else if (w_ovfEvt) begin
      if (!r_sat) begin
        r_a     <= r_seed0;
        r_b     <= r_seed1;
        r_count <= '0;
      end
    end else if (w_advance) begin
      r_a     <= r_b;
      r_b     <= w_sum[WIDTH-1:0];
      r_count <= r_count + 32'd1;
    end
  end

  // Prescaler counter: free-runs only while RUN is enabled and wraps at the
  // programmed reload, producing one tick every PRESCALE+1 cycles.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_clr || w_wrPre) begin
      r_cnt <= '0;
    end else if ((r_state == S_RUN) && r_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + PRESCALE_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-edge clear.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovfEvt) begin
      r_ovf <= 1'b1;
    end else if (w_wrStatus && wbs_dat_i[0]) begin
      r_ovf <= 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: a saturating overflow halts from either active state;
  // only CLR leaves HALT.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_satHalt) begin
          w_stateNext = S_HALT;
        end else if (r_en) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_satHalt) begin
          w_stateNext = S_HALT;
        end else if (!r_en) begin
          w_stateNext = S_IDLE;
        end
      end
      S_HALT: begin
        if (w_clr) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_datO;
  assign value     = r_a;
  assign running   = (r_state == S_RUN);
  assign irq       = r_ovf & r_irqEn;

endmodule
